// File: rtl/core_fetch_prefetch.sv
// core_fetch_prefetch
//   Prefetching instruction-fetch stage. Runs ahead of EXEC and fills a DEPTH-entry queue
//   of {instr, pc, access-fault} entries from I-mem. EXEC drains the head over valid/ready.
//   A redirect from EXEC (branch/jump) or from CSR (trap/xRET) flushes the queue and
//   restarts fetch at the new PC. CSR redirects take priority over EXEC redirects.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   fetch_en                     controller permits issuing new I-mem requests
//   instr_valid / instr_ready    head entry handshake towards EXEC
//   instr, pc, pc_plus_4         head entry instruction word, PC and PC + 4
//   ex_instr_access_fault        head entry was fetched with imem_err
//   pc_new_valid, pc_new         EXEC redirect
//   pc_csr_valid, pc_csr         CSR redirect (wins over EXEC redirect)
//   imem_valid/ready/addr        I-mem request; rdata/err are valid in the accept cycle
//   imem_rdata, imem_err         I-mem response
//   queue_count                  occupied queue entries (debug/perf)
module core_fetch_prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 4,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus_4,
  output logic          ex_instr_access_fault,
  input  logic          pc_new_valid,
  input  logic [31:0]   pc_new,
  input  logic          pc_csr_valid,
  input  logic [31:0]   pc_csr,
  output logic          imem_valid,
  input  logic          imem_ready,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_err,
  output logic [CW-1:0] queue_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage is deliberately left unreset; outputs are qualified by instr_valid.
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic        fault_mem [DEPTH];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_q, halt_d;

  logic        redirect;
  logic [31:0] target;
  logic        full;
  logic        enq;
  logic        deq;

  assign redirect = pc_csr_valid | pc_new_valid;
  assign target   = pc_csr_valid ? pc_csr : pc_new;

  // Full is taken from the registered count: a dequeue in the same cycle does not open a
  // slot for a request, which keeps the request path off the EXEC ready path.
  assign full = (count_q == CW'(DEPTH));

  assign imem_valid = fetch_en & ~full & ~halt_q & ~redirect;
  assign imem_addr  = fetch_pc_q;
  assign enq        = imem_valid & imem_ready;

  assign instr_valid = (count_q != '0);
  assign deq         = instr_valid & instr_ready;

  assign instr                 = instr_mem[rd_ptr_q];
  assign pc                    = pc_mem[rd_ptr_q];
  assign ex_instr_access_fault = fault_mem[rd_ptr_q];
  assign pc_plus_4             = pc_mem[rd_ptr_q] + 32'd4;
  assign queue_count           = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    halt_d     = halt_q;

    if (redirect) begin
      // Flush wins over any same-cycle dequeue; enq is already blocked by imem_valid.
      fetch_pc_d = target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      halt_d     = 1'b0;
    end else begin
      if (enq) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PW'(1);
        // A faulting fetch stops the stream until software redirects.
        if (imem_err) begin
          halt_d = 1'b1;
        end
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_VECTOR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      halt_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      halt_q     <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      fault_mem[wr_ptr_q] <= imem_err;
    end
  end

endmodule

// File: tb/tb_core_fetch_prefetch.sv
module tb_core_fetch_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   pc;
  logic [31:0]   pc_plus_4;
  logic          ex_instr_access_fault;
  logic          pc_new_valid;
  logic [31:0]   pc_new;
  logic          pc_csr_valid;
  logic [31:0]   pc_csr;
  logic          imem_valid;
  logic          imem_ready;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_err;
  logic [CW-1:0] queue_count;

  core_fetch_prefetch #(
    .RESET_VECTOR(RV),
    .DEPTH       (DEPTH)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .fetch_en             (fetch_en),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instr                (instr),
    .pc                   (pc),
    .pc_plus_4            (pc_plus_4),
    .ex_instr_access_fault(ex_instr_access_fault),
    .pc_new_valid         (pc_new_valid),
    .pc_new               (pc_new),
    .pc_csr_valid         (pc_csr_valid),
    .pc_csr               (pc_csr),
    .imem_valid           (imem_valid),
    .imem_ready           (imem_ready),
    .imem_addr            (imem_addr),
    .imem_rdata           (imem_rdata),
    .imem_err             (imem_err),
    .queue_count          (queue_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a plain queue of fetched entries, the next fetch address and a halt flag.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_halt;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit m_req();
    return fetch_en && (mq.size() < DEPTH) && !m_halt && !(pc_csr_valid || pc_new_valid);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = RV;
    m_halt = 0;
  endtask

  // Advance one clock; the model transition uses the inputs held across the edge.
  task automatic step();
    bit     red;
    bit     enq;
    bit     deq;
    entry_t e;
    red = pc_csr_valid || pc_new_valid;
    enq = m_req() && imem_ready;
    deq = (mq.size() != 0) && instr_ready;
    e   = '{instr: imem_rdata, pc: m_pc, fault: imem_err};
    @(posedge clk);
    #1;
    if (red) begin
      mq.delete();
      m_pc   = pc_csr_valid ? pc_csr : pc_new;
      m_halt = 0;
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) begin
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
        if (e.fault) m_halt = 1;
      end
    end
    imem_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    fetch_en     = 1'b0;
    instr_ready  = 1'b0;
    pc_new_valid = 1'b0;
    pc_new       = '0;
    pc_csr_valid = 1'b0;
    pc_csr       = '0;
    imem_ready   = 1'b0;
    imem_rdata   = $urandom;
    imem_err     = 1'b0;
    #12;
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %b want 0", instr_valid);
    else n_pass++;
    n_checks++;
    if (imem_valid !== 1'b0) $display("FAIL reset_imem_valid: got %b want 0", imem_valid);
    else n_pass++;
    n_checks++;
    if (queue_count !== CW'(0)) $display("FAIL reset_count: got %0d want 0", queue_count);
    else n_pass++;
    n_checks++;
    if (imem_addr !== RV) $display("FAIL reset_addr: got %h want %h", imem_addr, RV);
    else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    fetch_en   = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_checks++;
      if (imem_valid !== 1'b1 || imem_addr !== 32'(4 * i))
        $display("FAIL fill_req%0d: got valid=%b addr=%h want valid=1 addr=%h",
                 i, imem_valid, imem_addr, 32'(4 * i));
      else n_pass++;
      step();
    end
    n_checks++;
    if (queue_count !== CW'(DEPTH) || imem_valid !== 1'b0)
      $display("FAIL fill_full: got count=%0d imem_valid=%b want count=%0d imem_valid=0",
               queue_count, imem_valid, DEPTH);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== mq[0].instr)
      $display("FAIL fill_head: got v=%b pc=%h instr=%h want v=1 pc=0 instr=%h",
               instr_valid, pc, instr, mq[0].instr);
    else n_pass++;
  endtask

  task automatic test_full_deq();
    instr_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_valid !== 1'b0) $display("FAIL full_bubble: got imem_valid=%b want 0", imem_valid);
    else n_pass++;
    step();
    instr_ready = 1'b0;
    #1;
    n_checks++;
    if (queue_count !== CW'(DEPTH - 1) || imem_valid !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL full_refill: got count=%0d v=%b addr=%h want count=%0d v=1 addr=10",
               queue_count, imem_valid, imem_addr, DEPTH - 1);
    else n_pass++;
    n_checks++;
    if (pc !== 32'h4) $display("FAIL full_head_pc: got %h want 4", pc);
    else n_pass++;
    step();
    n_checks++;
    if (queue_count !== CW'(DEPTH)) $display("FAIL full_refilled: got %0d want %0d", queue_count, DEPTH);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] prev_pc;
    instr_ready = 1'b1;
    imem_ready  = 1'b1;
    fetch_en    = 1'b1;
    prev_pc     = mq[0].pc;
    for (int i = 0; i < 12; i++) begin
      step();
      #1;
      n_checks++;
      if (instr_valid !== 1'b1 || pc !== mq[0].pc || instr !== mq[0].instr ||
          pc_plus_4 !== mq[0].pc + 32'd4 || pc !== prev_pc + 32'd4)
        $display("FAIL stream%0d: got v=%b pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                 i, instr_valid, pc, instr, pc_plus_4, mq[0].pc, mq[0].instr, mq[0].pc + 32'd4);
      else n_pass++;
      prev_pc = mq[0].pc;
      if (i >= 2) begin
        n_checks++;
        if (queue_count !== CW'(DEPTH - 1))
          $display("FAIL stream_count%0d: got %0d want %0d", i, queue_count, DEPTH - 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_redirect_new();
    do_reset();
    fetch_en   = 1'b1;
    imem_ready = 1'b1;
    repeat (3) step();
    imem_ready   = 1'b0;
    pc_new_valid = 1'b1;
    pc_new       = 32'h100;
    #1;
    n_checks++;
    if (queue_count !== CW'(3) || imem_valid !== 1'b0)
      $display("FAIL redir_pre: got count=%0d v=%b want count=3 v=0", queue_count, imem_valid);
    else n_pass++;
    step();
    pc_new_valid = 1'b0;
    imem_ready   = 1'b1;
    #1;
    n_checks++;
    if (queue_count !== CW'(0) || imem_valid !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL redir_flush: got count=%0d v=%b addr=%h want 0 1 100",
               queue_count, imem_valid, imem_addr);
    else n_pass++;
    step();
    n_checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== mq[0].instr)
      $display("FAIL redir_first: got v=%b pc=%h instr=%h want v=1 pc=100 instr=%h",
               instr_valid, pc, instr, mq[0].instr);
    else n_pass++;
  endtask

  task automatic test_redirect_priority();
    pc_new_valid = 1'b1;
    pc_new       = 32'h100;
    pc_csr_valid = 1'b1;
    pc_csr       = 32'h200;
    step();
    pc_new_valid = 1'b0;
    pc_csr_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_valid !== 1'b1 || imem_addr !== 32'h200 || queue_count !== CW'(0))
      $display("FAIL redir_prio: got v=%b addr=%h count=%0d want 1 200 0",
               imem_valid, imem_addr, queue_count);
    else n_pass++;
  endtask

  task automatic test_fault();
    do_reset();
    fetch_en   = 1'b1;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_err = (m_pc == 32'h8);
      step();
    end
    imem_err = 1'b0;
    #1;
    n_checks++;
    if (imem_valid !== 1'b0 || queue_count !== CW'(3))
      $display("FAIL fault_halt: got v=%b count=%0d want v=0 count=3", imem_valid, queue_count);
    else n_pass++;
    instr_ready = 1'b1;
    repeat (2) step();
    instr_ready = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h8 || ex_instr_access_fault !== 1'b1)
      $display("FAIL fault_entry: got v=%b pc=%h fault=%b want 1 8 1",
               instr_valid, pc, ex_instr_access_fault);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (imem_valid !== 1'b0) $display("FAIL fault_stay_halted: got v=%b want 0", imem_valid);
    else n_pass++;
    pc_csr_valid = 1'b1;
    pc_csr       = 32'h80;
    step();
    pc_csr_valid = 1'b0;
    #1;
    n_checks++;
    if (imem_valid !== 1'b1 || imem_addr !== 32'h80 || queue_count !== CW'(0))
      $display("FAIL fault_resume: got v=%b addr=%h count=%0d want 1 80 0",
               imem_valid, imem_addr, queue_count);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      fetch_en     = ($urandom_range(0, 9) < 8);
      imem_ready   = $urandom_range(0, 1);
      instr_ready  = $urandom_range(0, 1);
      imem_err     = ($urandom_range(0, 19) == 0);
      pc_new_valid = ($urandom_range(0, 15) == 0);
      pc_csr_valid = ($urandom_range(0, 23) == 0);
      pc_new       = {$urandom} & 32'hFFFF_FFFC;
      pc_csr       = (i % 50 == 0) ? 32'hFFFF_FFF8 : ({$urandom} & 32'hFFFF_FFFC);
      #1;
      n_checks++;
      if (imem_valid !== m_req() || (m_req() && imem_addr !== m_pc))
        $display("FAIL rnd_req%0d: got v=%b addr=%h want v=%b addr=%h",
                 i, imem_valid, imem_addr, m_req(), m_pc);
      else n_pass++;
      n_checks++;
      if (queue_count !== CW'(mq.size()) || instr_valid !== (mq.size() != 0))
        $display("FAIL rnd_count%0d: got count=%0d v=%b want count=%0d",
                 i, queue_count, instr_valid, mq.size());
      else n_pass++;
      if (mq.size() != 0) begin
        n_checks++;
        if (instr !== mq[0].instr || pc !== mq[0].pc || ex_instr_access_fault !== mq[0].fault ||
            pc_plus_4 !== mq[0].pc + 32'd4)
          $display("FAIL rnd_head%0d: got %h/%h/%b/%h want %h/%h/%b/%h", i, instr, pc,
                   ex_instr_access_fault, pc_plus_4, mq[0].instr, mq[0].pc, mq[0].fault,
                   mq[0].pc + 32'd4);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    fetch_en     = 1'b1;
    imem_ready   = 1'b1;
    instr_ready  = 1'b0;
    imem_err     = 1'b0;
    pc_new_valid = 1'b1;
    pc_new       = 32'h40;
    step();
    pc_new_valid = 1'b0;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (queue_count !== CW'(0) || instr_valid !== 1'b0 || imem_addr !== RV)
      $display("FAIL async_reset: got count=%0d v=%b addr=%h want 0 0 %h",
               queue_count, instr_valid, imem_addr, RV);
    else n_pass++;
    #10;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_full_deq();
    test_stream();
    test_redirect_new();
    test_redirect_priority();
    test_fault();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
